// File: rtl/uart_rx_ex.sv
// rtl/uart_rx_ex.sv - UART receiver with runtime divider, 3-sample vote, parity and error flags
module uart_rx_ex #(
    parameter int NUMBER_OF_BITS = 8,
    parameter int DIVIDER_BITS   = 16,
    parameter int RX_SYNC_STAGES = 2,
    parameter int PARITY_MODE    = 0,
    parameter int STOP_BITS      = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [DIVIDER_BITS-1:0]   baud_divider,
    input  logic                      rx,
    output logic                      data_valid,
    input  logic                      data_ready,
    output logic [NUMBER_OF_BITS-1:0] data_bits,
    output logic                      parity_error,
    output logic                      framing_error,
    output logic                      break_detect,
    output logic                      overrun
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam logic [DIVIDER_BITS-1:0] ONE      = DIVIDER_BITS'(1);
    localparam logic [3:0]              LAST_BIT = 4'(NUMBER_OF_BITS - 1);
    localparam logic [3:0]              LAST_STP = 4'(STOP_BITS - 1);

    state_t                      state_q, state_d;
    logic [RX_SYNC_STAGES-1:0]   sync_q, sync_d;
    logic                        s_dly_q, s_dly_d;
    logic [DIVIDER_BITS-1:0]     dl_q, dl_d;
    logic [DIVIDER_BITS-1:0]     phase_q, phase_d;
    logic [3:0]                  bit_cnt_q, bit_cnt_d;
    logic                        samp_a_q, samp_a_d;
    logic                        samp_b_q, samp_b_d;
    logic [NUMBER_OF_BITS-1:0]   shift_q, shift_d;
    logic                        par_q, par_d;
    logic                        fe_q, fe_d;

    logic                        data_valid_q, data_valid_d;
    logic [NUMBER_OF_BITS-1:0]   data_bits_q, data_bits_d;
    logic                        parity_error_q, parity_error_d;
    logic                        framing_error_q, framing_error_d;
    logic                        break_detect_q, break_detect_d;
    logic                        overrun_q, overrun_d;

    logic                        s;
    logic [DIVIDER_BITS-1:0]     half;
    logic                        at_early, at_mid, at_resolve, at_end;
    logic                        maj;
    logic                        frame_done;
    logic                        done_fe, done_pe, done_brk;

    assign s          = sync_q[RX_SYNC_STAGES-1];
    assign half       = dl_q >> 1;
    assign at_early   = (phase_q == half - ONE);
    assign at_mid     = (phase_q == half);
    assign at_resolve = (phase_q == half + ONE);
    assign at_end     = (phase_q == dl_q - ONE);
    // Third vote is the live sample at the resolve phase.
    assign maj        = (samp_a_q & samp_b_q) | (samp_a_q & s) | (samp_b_q & s);

    always_comb begin
        state_d    = state_q;
        sync_d     = {sync_q[RX_SYNC_STAGES-2:0], rx};
        s_dly_d    = s;
        dl_d       = dl_q;
        phase_d    = at_end ? '0 : phase_q + ONE;
        bit_cnt_d  = bit_cnt_q;
        samp_a_d   = at_early ? s : samp_a_q;
        samp_b_d   = at_mid ? s : samp_b_q;
        shift_d    = shift_q;
        par_d      = par_q;
        fe_d       = fe_q;
        frame_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                phase_d = '0;
                if (s_dly_q && !s) begin
                    state_d = ST_START;
                    dl_d    = baud_divider;
                end
            end
            ST_START: begin
                fe_d = 1'b0;
                if (at_resolve && maj) begin
                    state_d = ST_IDLE;
                end else if (at_end) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (at_resolve) begin
                    shift_d = {maj, shift_q[NUMBER_OF_BITS-1:1]};
                end
                if (at_end) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (at_resolve) begin
                    par_d = maj;
                end
                if (at_end) begin
                    state_d   = ST_STOP;
                    bit_cnt_d = '0;
                end
            end
            ST_STOP: begin
                if (at_resolve && !maj) begin
                    fe_d = 1'b1;
                end
                // Finish at the last stop bit's vote so a following start edge is not missed.
                if (at_resolve && bit_cnt_q == LAST_STP) begin
                    frame_done = 1'b1;
                    state_d    = ST_IDLE;
                end else if (at_end) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        done_fe  = fe_q | ~maj;
        done_pe  = 1'b0;
        if (PARITY_MODE == 1) begin
            done_pe = (^shift_q) ^ par_q;
        end else if (PARITY_MODE == 2) begin
            done_pe = ~((^shift_q) ^ par_q);
        end
        done_brk = done_fe && (shift_q == '0) && ((PARITY_MODE == 0) || !par_q);
    end

    always_comb begin
        data_valid_d    = data_valid_q;
        data_bits_d     = data_bits_q;
        parity_error_d  = parity_error_q;
        framing_error_d = framing_error_q;
        break_detect_d  = break_detect_q;
        overrun_d       = 1'b0;

        if (data_valid_q && data_ready) begin
            data_valid_d = 1'b0;
        end
        if (frame_done) begin
            if (!data_valid_q || data_ready) begin
                data_valid_d    = 1'b1;
                data_bits_d     = shift_q;
                parity_error_d  = done_pe;
                framing_error_d = done_fe;
                break_detect_d  = done_brk;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            sync_q          <= '1;
            s_dly_q         <= 1'b1;
            dl_q            <= '0;
            phase_q         <= '0;
            bit_cnt_q       <= '0;
            samp_a_q        <= 1'b1;
            samp_b_q        <= 1'b1;
            shift_q         <= '0;
            par_q           <= 1'b0;
            fe_q            <= 1'b0;
            data_valid_q    <= 1'b0;
            data_bits_q     <= '0;
            parity_error_q  <= 1'b0;
            framing_error_q <= 1'b0;
            break_detect_q  <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            sync_q          <= sync_d;
            s_dly_q         <= s_dly_d;
            dl_q            <= dl_d;
            phase_q         <= phase_d;
            bit_cnt_q       <= bit_cnt_d;
            samp_a_q        <= samp_a_d;
            samp_b_q        <= samp_b_d;
            shift_q         <= shift_d;
            par_q           <= par_d;
            fe_q            <= fe_d;
            data_valid_q    <= data_valid_d;
            data_bits_q     <= data_bits_d;
            parity_error_q  <= parity_error_d;
            framing_error_q <= framing_error_d;
            break_detect_q  <= break_detect_d;
            overrun_q       <= overrun_d;
        end
    end

    assign data_valid    = data_valid_q;
    assign data_bits     = data_bits_q;
    assign parity_error  = parity_error_q;
    assign framing_error = framing_error_q;
    assign break_detect  = break_detect_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_rx_ex.sv
// tb/tb_uart_rx_ex.sv - directed bench for uart_rx_ex (8N1 and 8E1 instances)
module tb_uart_rx_ex;

    logic        clock;
    logic        reset;
    logic [15:0] baud_divider;
    logic        line_val;
    logic        use_par;
    logic        rx, rx_p;
    logic        data_ready, data_ready_p;
    logic        data_valid, data_valid_p;
    logic [7:0]  data_bits, data_bits_p;
    logic        parity_error, parity_error_p;
    logic        framing_error, framing_error_p;
    logic        break_detect, break_detect_p;
    logic        overrun, overrun_p;
    logic        dv_sel;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int ovr_cnt  = 0;

    assign rx     = use_par ? 1'b1 : line_val;
    assign rx_p   = use_par ? line_val : 1'b1;
    assign dv_sel = use_par ? data_valid_p : data_valid;

    uart_rx_ex #(.NUMBER_OF_BITS(8), .DIVIDER_BITS(16), .RX_SYNC_STAGES(2),
                 .PARITY_MODE(0), .STOP_BITS(1)) dut (
        .clock(clock), .reset(reset), .baud_divider(baud_divider), .rx(rx),
        .data_valid(data_valid), .data_ready(data_ready), .data_bits(data_bits),
        .parity_error(parity_error), .framing_error(framing_error),
        .break_detect(break_detect), .overrun(overrun));

    uart_rx_ex #(.NUMBER_OF_BITS(8), .DIVIDER_BITS(16), .RX_SYNC_STAGES(2),
                 .PARITY_MODE(1), .STOP_BITS(1)) dut_par (
        .clock(clock), .reset(reset), .baud_divider(baud_divider), .rx(rx_p),
        .data_valid(data_valid_p), .data_ready(data_ready_p), .data_bits(data_bits_p),
        .parity_error(parity_error_p), .framing_error(framing_error_p),
        .break_detect(break_detect_p), .overrun(overrun_p));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) if (overrun) ovr_cnt <= ovr_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Falling edge -> data_valid: sync stages + 1 + D*K + D/2 + 2
    function automatic int exp_lat(input int d, input int k);
        return 2 + 1 + d * k + (d >> 1) + 2;
    endfunction

    task automatic send_frame(input int d, input logic [15:0] bits, input int nbits,
                              input int gbit, input int goff);
        line_val = 1'b0;
        tick(d);
        for (int i = 0; i < nbits; i++) begin
            for (int k = 0; k < d; k++) begin
                line_val = bits[i] ^ ((i == gbit && k == goff) ? 1'b1 : 1'b0);
                tick(1);
            end
        end
        line_val = 1'b1;
    endtask

    task automatic wait_valid(input int budget, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (dv_sel) begin
                at_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic rx_frame(input int d, input logic [15:0] bits, input int nbits,
                            input int gbit, input int goff, output int lat);
        int c0, at;
        c0 = cyc;
        fork
            send_frame(d, bits, nbits, gbit, goff);
            wait_valid(d * (nbits + 2) + 20, at);
        join
        lat = (at < 0) ? -1 : at - c0;
    endtask

    task automatic accept_word();
        data_ready = 1'b1;
        tick(1);
        data_ready = 1'b0;
    endtask

    initial begin
        int lat, unstable, frames, base, c0;
        logic [7:0] cap_data, held;
        logic       cap_fe, cap_bd;

        reset = 1'b1; line_val = 1'b1; use_par = 1'b0;
        data_ready = 1'b0; data_ready_p = 1'b0; baud_divider = 16'd16;
        tick(4);
        reset = 1'b0;
        tick(2);
        check("rst_valid", data_valid, 0);
        check("rst_data", data_bits, 0);
        check("rst_perr", parity_error, 0);
        check("rst_ferr", framing_error, 0);
        check("rst_brk", break_detect, 0);
        check("rst_ovr", overrun, 0);

        rx_frame(16, 16'h1A5, 9, -1, 0, lat);
        check("a5_latency", lat, exp_lat(16, 9));
        check("a5_data", data_bits, 8'hA5);
        check("a5_perr", parity_error, 0);
        check("a5_ferr", framing_error, 0);
        check("a5_brk", break_detect, 0);
        unstable = 0;
        held = data_bits;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (!data_valid || data_bits !== held) unstable++;
        end
        check("a5_hold_stable", unstable, 0);
        tick(1);
        accept_word();
        check("a5_drop_after_ready", data_valid, 0);

        use_par = 1'b1;
        rx_frame(16, 16'h203, 10, -1, 0, lat);
        check("par_ok_latency", lat, exp_lat(16, 10));
        check("par_ok_data", data_bits_p, 8'h03);
        check("par_ok_perr", parity_error_p, 0);
        data_ready_p = 1'b1; tick(1); data_ready_p = 1'b0;
        rx_frame(16, 16'h303, 10, -1, 0, lat);
        check("par_bad_data", data_bits_p, 8'h03);
        check("par_bad_perr", parity_error_p, 1);
        data_ready_p = 1'b1; tick(1); data_ready_p = 1'b0;
        check("par_drop", data_valid_p, 0);
        use_par = 1'b0;
        tick(5);

        line_val = 1'b0; tick(3); line_val = 1'b1;
        frames = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (data_valid) frames++;
        end
        check("glitch_no_frame", frames, 0);
        tick(1);
        rx_frame(16, 16'h15A, 9, 0, 9, lat);
        check("hi_glitch_data", data_bits, 8'h5A);
        check("hi_glitch_ferr", framing_error, 0);
        accept_word();

        rx_frame(16, 16'h03C, 9, -1, 0, lat);
        check("stop0_data", data_bits, 8'h3C);
        check("stop0_ferr", framing_error, 1);
        check("stop0_brk", break_detect, 0);
        accept_word();
        tick(5);

        data_ready = 1'b1;
        line_val = 1'b0;
        frames = 0; cap_data = 8'hFF; cap_fe = 1'b0; cap_bd = 1'b0;
        for (int i = 0; i < 480; i++) begin
            @(negedge clock);
            if (data_valid) begin
                frames++;
                cap_data = data_bits; cap_fe = framing_error; cap_bd = break_detect;
            end
        end
        check("break_one_frame", frames, 1);
        check("break_data", cap_data, 8'h00);
        check("break_ferr", cap_fe, 1);
        check("break_flag", cap_bd, 1);
        tick(1);
        line_val = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (data_valid) frames++;
        end
        check("break_no_more", frames, 1);
        tick(1);
        data_ready = 1'b0;

        rx_frame(16, 16'h111, 9, -1, 0, lat);
        base = ovr_cnt;
        send_frame(16, 16'h122, 9, -1, 0);
        tick(5);
        check("ovr_pulses", ovr_cnt - base, 1);
        check("ovr_held_data", data_bits, 8'h11);
        check("ovr_held_valid", data_valid, 1);
        base = ovr_cnt;
        c0 = cyc;
        fork
            send_frame(16, 16'h122, 9, -1, 0);
            begin
                tick(exp_lat(16, 9) - 1);
                data_ready = 1'b1;
                tick(1);
                data_ready = 1'b0;
            end
        join
        check("ready_cc_valid", data_valid, 1);
        check("ready_cc_data", data_bits, 8'h22);
        check("ready_cc_no_ovr", ovr_cnt - base, 0);
        accept_word();

        baud_divider = 16'd4;
        rx_frame(4, 16'h1FF, 9, -1, 0, lat);
        check("d4_latency", lat, exp_lat(4, 9));
        check("d4_data", data_bits, 8'hFF);
        accept_word();
        tick(3);
        baud_divider = 16'd100;
        fork
            rx_frame(100, 16'h181, 9, -1, 0, lat);
            begin
                tick(300);
                baud_divider = 16'd7;
            end
        join
        check("d100_latency", lat, exp_lat(100, 9));
        check("d100_data", data_bits, 8'h81);
        baud_divider = 16'd16;
        tick(3);

        line_val = 1'b0;
        tick(60);
        reset = 1'b1;
        line_val = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("midrst_valid", data_valid, 0);
        check("midrst_data", data_bits, 0);
        check("midrst_ferr", framing_error, 0);
        tick(5);
        rx_frame(16, 16'h17E, 9, -1, 0, lat);
        check("post_rst_latency", lat, exp_lat(16, 9));
        check("post_rst_data", data_bits, 8'h7E);
        check("post_rst_ferr", framing_error, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
